// File: rtl/rwc_challenger.sv
// Challenge sequencer and response collector for the read-write collision PUF generator.
// Issues LFSR-generated challenges, runs the generator handshake and returns one result per challenge.
module rwc_challenger #(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic [10:0] num_cha,
    input  logic [31:0] seed,
    input  logic        available,
    input  logic [31:0] rsp_write,
    input  logic [31:0] rsp_clean,
    output logic        gen_enable,
    output logic [9:0]  cha_addr,
    output logic [31:0] cha_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [9:0]  res_addr,
    output logic [31:0] res_flip,
    output logic [31:0] res_clean,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, OUTPUT, NEXT} state_t;

    state_t          state, state_nxt;
    logic [9:0]      addr_cnt;
    logic [10:0]     remain;
    logic [31:0]     lfsr;
    logic [TW-1:0]   tmo_cnt;
    logic            load, tmo_clr, tmo_inc, set_err, capture, advance;
    logic            tmo_hit;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    assign res_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign cha_addr  = addr_cnt;
    assign cha_data  = lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        gen_enable = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        set_err    = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (available) begin
                    gen_enable = 1'b1;
                    tmo_clr    = 1'b1;
                    state_nxt  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!available) begin
                    tmo_clr   = 1'b1;
                    state_nxt = WAIT_HI;
                end else if (tmo_hit) begin
                    set_err   = 1'b1;
                    state_nxt = NEXT;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            WAIT_HI: begin
                if (available) begin
                    capture   = 1'b1;
                    state_nxt = OUTPUT;
                end else if (tmo_hit) begin
                    set_err   = 1'b1;
                    state_nxt = NEXT;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            OUTPUT: begin
                if (res_ready) state_nxt = NEXT;
            end
            NEXT: begin
                advance = 1'b1;
                if (remain == 11'd1) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Challenge generation: address counter, remaining count, LFSR and timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= 10'd0;
            remain   <= 11'd0;
            lfsr     <= 32'h1;
            tmo_cnt  <= '0;
            error    <= 1'b0;
        end else begin
            if (load) begin
                addr_cnt <= base_addr;
                remain   <= (num_cha == 11'd0) ? 11'd1024 : num_cha;
                lfsr     <= (seed == 32'h0) ? 32'h1 : seed;
            end else if (advance) begin
                addr_cnt <= addr_cnt + 10'd1;
                remain   <= remain - 11'd1;
                lfsr     <= lfsr_step(lfsr);
            end
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
            if (load)         error <= 1'b0;
            else if (set_err) error <= 1'b1;
        end
    end

    // Result capture: held stable for the whole OUTPUT phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_addr  <= 10'd0;
            res_flip  <= 32'h0;
            res_clean <= 32'h0;
        end else if (capture) begin
            res_addr  <= addr_cnt;
            res_flip  <= rsp_write ^ lfsr;
            res_clean <= rsp_clean;
        end
    end

endmodule

// File: tb/tb_rwc_challenger.sv
// Table-driven bench for rwc_challenger with a behavioural generator model
// (available falls 2 cycles after gen_enable and rises 4 cycles later).
module tb_rwc_challenger;

    logic        clk, rst_n, start, available, res_ready;
    logic [9:0]  base_addr;
    logic [10:0] num_cha;
    logic [31:0] seed, rsp_write, rsp_clean;
    logic        gen_enable, res_valid, busy, done, error;
    logic [9:0]  cha_addr, res_addr;
    logic [31:0] cha_data, res_flip, res_clean;

    logic [31:0] flip_pat, clean_pat;
    logic        nodrop_once;

    int n_pass = 0;
    int n_tot  = 0;

    logic [31:0] q_data[$];
    logic [9:0]  q_raddr[$];
    logic [31:0] q_rflip[$], q_rclean[$];
    int          q_gcyc[$], q_xcyc[$];
    int          n_done, done_cyc;

    rwc_challenger dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_cha(num_cha), .seed(seed), .available(available),
        .rsp_write(rsp_write), .rsp_clean(rsp_clean), .gen_enable(gen_enable),
        .cha_addr(cha_addr), .cha_data(cha_data), .res_valid(res_valid),
        .res_ready(res_ready), .res_addr(res_addr), .res_flip(res_flip),
        .res_clean(res_clean), .busy(busy), .done(done), .error(error)
    );

    assign rsp_write = cha_data ^ {22'h0, cha_addr} ^ flip_pat;
    assign rsp_clean = clean_pat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generator model, updated 2 time units after each rising edge
    initial begin
        int   phase;
        logic drop_this;
        phase     = 0;
        drop_this = 1'b1;
        available = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                phase     = 0;
                available = 1'b1;
            end else if (phase == 0) begin
                if (gen_enable) begin
                    phase       = 1;
                    drop_this   = !nodrop_once;
                    nodrop_once = 1'b0;
                end
            end else begin
                phase = phase + 1;
                if (phase == 3 && drop_this) available = 1'b0;
                if (phase == 7) begin
                    available = 1'b1;
                    phase     = 0;
                end
            end
        end
    end

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic start_run(input logic [9:0] b, input logic [10:0] n, input logic [31:0] s);
        q_data.delete(); q_raddr.delete(); q_rflip.delete(); q_rclean.delete();
        q_gcyc.delete(); q_xcyc.delete();
        n_done = 0; done_cyc = 0;
        @(negedge clk);
        base_addr = b; num_cha = n; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int max_cyc);
        logic finished;
        finished = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (gen_enable) begin
                q_data.push_back(cha_data);
                q_gcyc.push_back(i);
            end
            if (res_valid && res_ready) begin
                q_raddr.push_back(res_addr);
                q_rflip.push_back(res_flip);
                q_rclean.push_back(res_clean);
                q_xcyc.push_back(i);
            end
            if (done) begin
                n_done++;
                done_cyc = i;
            end
            @(negedge clk);
            if (n_done > 0 && !busy) begin
                finished = 1'b1;
                break;
            end
        end
        chk("run_completes", finished, 1);
    endtask

    task automatic check_seq(input logic [9:0] b, input logic [31:0] s);
        logic [31:0] d;
        logic [9:0]  a;
        int          bad;
        bad = 0;
        d = (s == 32'h0) ? 32'h1 : s;
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_data[i] !== d) bad++;
            d = ref_step(d);
        end
        for (int i = 0; i < q_raddr.size(); i++) begin
            a = b + 10'(i);
            if (q_raddr[i] !== a) bad++;
            if (q_rflip[i] !== ({22'h0, a} ^ flip_pat)) bad++;
            if (q_rclean[i] !== clean_pat) bad++;
        end
        chk("seq_model", bad, 0);
    endtask

    typedef struct {
        logic [9:0]  base;
        logic [10:0] num;
        logic [31:0] seed;
        logic [31:0] flip;
        logic [31:0] clean;
        logic [31:0] exp_flip0;
        logic [9:0]  exp_last;
        logic [31:0] exp_data1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int last, bad, gap;
        vecs[0] = '{10'd5,    11'd1, 32'hA5A5A5A5, 32'h00000004, 32'h00000000, 32'h00000001, 10'd5,   32'h0};
        vecs[1] = '{10'd1022, 11'd3, 32'h00000001, 32'h00000000, 32'hDEADBEEF, 32'h000003FE, 10'd0,   32'h80200003};
        vecs[2] = '{10'd100,  11'd2, 32'h00000000, 32'hFFFF0000, 32'h12345678, 32'hFFFF0064, 10'd101, 32'h80200003};
        vecs[3] = '{10'd0,    11'd4, 32'h00000002, 32'h00000010, 32'h00000000, 32'h00000010, 10'd3,   32'h00000001};

        rst_n = 1'b1; start = 1'b0; res_ready = 1'b1; nodrop_once = 1'b0;
        base_addr = '0; num_cha = '0; seed = '0; flip_pat = '0; clean_pat = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {gen_enable, res_valid, busy, done, error}, 5'b0);
        chk("rst_cha", {cha_addr, cha_data}, {10'd0, 32'h1});
        chk("rst_res", {res_addr, res_flip, res_clean}, 74'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            flip_pat  = vecs[v].flip;
            clean_pat = vecs[v].clean;
            start_run(vecs[v].base, vecs[v].num, vecs[v].seed);
            collect(int'(vecs[v].num) * 20 + 20);
            last = q_raddr.size() - 1;
            chk($sformatf("v%0d_n_gen", v), q_data.size(), vecs[v].num);
            chk($sformatf("v%0d_n_res", v), q_raddr.size(), vecs[v].num);
            chk($sformatf("v%0d_done_cnt", v), n_done, 1);
            chk($sformatf("v%0d_flip0", v), q_rflip[0], vecs[v].exp_flip0);
            chk($sformatf("v%0d_clean0", v), q_rclean[0], vecs[v].clean);
            chk($sformatf("v%0d_last_addr", v), q_raddr[last], vecs[v].exp_last);
            chk($sformatf("v%0d_done_lat", v), done_cyc - q_xcyc[last], 1);
            if (vecs[v].num >= 11'd2) begin
                chk($sformatf("v%0d_data1", v), q_data[1], vecs[v].exp_data1);
                gap = q_gcyc[1] - q_xcyc[0];
                chk($sformatf("v%0d_issue_gap", v), gap, 2);
            end
            check_seq(vecs[v].base, vecs[v].seed);
            chk($sformatf("v%0d_idle", v), {busy, error}, 2'b00);
        end

        // Back-pressure with an ignored start during the stall
        flip_pat = 32'h0; clean_pat = 32'h0000CAFE; res_ready = 1'b0;
        start_run(10'd200, 11'd2, 32'h00001234);
        for (int i = 0; i < 40; i++) begin
            if (res_valid) break;
            @(negedge clk);
        end
        chk("bp_valid_seen", res_valid, 1);
        chk("bp_fields", {res_addr, res_flip, res_clean}, {10'd200, 32'h000000C8, 32'h0000CAFE});
        base_addr = 10'd999; num_cha = 11'd1; seed = 32'h7; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("bp_stable", {res_valid, gen_enable, res_addr, res_flip, res_clean},
                {1'b1, 1'b0, 10'd200, 32'h000000C8, 32'h0000CAFE});
        end
        res_ready = 1'b1;
        collect(60);
        chk("bp_n_res", q_raddr.size(), 2);
        chk("bp_addr2", q_raddr[1], 10'd201);
        chk("bp_done", n_done, 1);

        // Timeout: first challenge never sees available drop
        nodrop_once = 1'b1; flip_pat = 32'h0; clean_pat = 32'h0;
        start_run(10'd300, 11'd2, 32'h5);
        for (int i = 0; i < 5; i++) begin
            if (gen_enable) break;
            @(negedge clk);
        end
        chk("to_gen_seen", gen_enable, 1);
        repeat (16) @(negedge clk);
        chk("to_err_before", error, 0);
        @(negedge clk);
        chk("to_err_after", {error, busy}, 2'b11);
        collect(60);
        chk("to_n_res", q_raddr.size(), 1);
        chk("to_addr", q_raddr[0], 10'd301);
        chk("to_done", n_done, 1);
        chk("to_err_sticky", error, 1);

        // Reset in WAIT_HI, then seed 0 and num_cha 0
        start_run(10'd50, 11'd3, 32'h77);
        chk("err_clr_on_start", error, 0);
        for (int i = 0; i < 20; i++) begin
            if (!available) break;
            @(negedge clk);
        end
        chk("rs_avail_low", available, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_ctrl", {gen_enable, res_valid, busy, done, error}, 5'b0);
        chk("rs_cha", {cha_addr, cha_data}, {10'd0, 32'h1});
        chk("rs_res", {res_addr, res_flip, res_clean}, 74'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        chk("rs_no_done", bad, 0);

        flip_pat = 32'h0F0F0F0F; clean_pat = 32'h55AA55AA;
        start_run(10'd7, 11'd0, 32'h0);
        chk("s0_first_data", cha_data, 32'h1);
        collect(1024 * 12 + 50);
        chk("s0_n_gen", q_data.size(), 1024);
        chk("s0_n_res", q_raddr.size(), 1024);
        chk("s0_last_addr", q_raddr[1023], 10'd6);
        chk("s0_done", n_done, 1);
        check_seq(10'd7, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
